// File: rtl/seg7_pkg.sv
// Shared constants for the four-digit seven-segment scan driver:
// blank pattern, active-low hex font (g..a) and default guard time.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam int GUARD_DEFAULT = 2;

  // Index 0 is the last element of the concatenation.
  localparam logic [15:0][6:0] FONT = {
    7'h0E, 7'h06, 7'h21, 7'h46,
    7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19,
    7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-low seven-segment pattern.
// Bit 6 is segment g, bit 0 is segment a.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  // Font lookup
  assign seg_n = FONT[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed hex display driver with frame-synchronous
// capture, leading-zero blanking, PWM dimming and anode guard time.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGIT_CYCLES = 50000,
  parameter int GUARD_CYCLES = GUARD_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] value,
  input  logic [3:0]  dp,
  input  logic        blank_lz,
  input  logic [3:0]  brightness,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic [3:0]  an_n,
  output logic        frame_tick
);

  localparam int CW = $clog2(DIGIT_CYCLES);
  localparam logic [CW-1:0] SLOT_LAST = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] GUARD = CW'(GUARD_CYCLES);

  logic [CW-1:0] slot_cnt;
  logic [1:0]    idx;
  logic [3:0]    pwm_cnt;

  logic [15:0] shadow_value;
  logic [3:0]  shadow_dp;
  logic        shadow_blank_lz;
  logic [3:0]  shadow_brightness;

  logic        slot_wrap;
  logic        frame_start;
  logic [15:0] upper;
  logic [3:0]  nibble;
  logic [6:0]  seg_dec;
  logic        blanked;
  logic        pwm_on;
  logic        an_on;

  assign slot_wrap   = (slot_cnt == SLOT_LAST);
  assign frame_start = slot_wrap && (idx == 2'd3);

  // Slot counter and digit index
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_cnt <= '0;
      idx      <= '0;
    end else if (slot_wrap) begin
      slot_cnt <= '0;
      idx      <= idx + 2'd1;
    end else begin
      slot_cnt <= slot_cnt + CW'(1);
    end
  end

  // Free-running PWM phase
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pwm_cnt <= '0;
    else          pwm_cnt <= pwm_cnt + 4'd1;
  end

  // Shadow capture only at frame start, so a frame never tears
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_value      <= '0;
      shadow_dp         <= '0;
      shadow_blank_lz   <= 1'b0;
      shadow_brightness <= '0;
    end else if (frame_start) begin
      shadow_value      <= value;
      shadow_dp         <= dp;
      shadow_blank_lz   <= blank_lz;
      shadow_brightness <= brightness;
    end
  end

  assign upper  = shadow_value >> {idx, 2'b00};
  assign nibble = upper[3:0];

  seg7_hex_decode u_dec (
    .nibble (nibble),
    .seg_n  (seg_dec)
  );

  // Digit is blank when it and every digit above it are zero
  assign blanked = shadow_blank_lz && (idx != 2'd0) && (upper == 16'h0);

  assign pwm_on = (shadow_brightness == 4'hF) ||
                  (pwm_cnt < shadow_brightness);

  assign an_on = !blanked && pwm_on && (slot_cnt >= GUARD);

  // Registered pin drivers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg_n      <= SEG_BLANK;
      dp_n       <= 1'b1;
      an_n       <= 4'hF;
      frame_tick <= 1'b0;
    end else begin
      seg_n      <= blanked ? SEG_BLANK : seg_dec;
      dp_n       <= blanked | ~shadow_dp[idx];
      an_n       <= an_on ? ~(4'b0001 << idx) : 4'hF;
      frame_tick <= frame_start;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomised and directed bench for seg7_scan_driver against a
// cycle-count reference model of the display behaviour.
module tb_seg7_scan_driver;

  localparam int DC    = 16;
  localparam int GC    = 2;
  localparam int FRAME = 4 * DC;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp = '0;
  logic        blank_lz = 1'b0;
  logic [3:0]  brightness = '0;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  an_n;
  logic        frame_tick;

  int n_checks = 0;
  int n_errors = 0;

  int          e;
  logic [15:0] m_val;
  logic [3:0]  m_dp;
  logic        m_blz;
  logic [3:0]  m_br;

  logic [6:0] font [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  seg7_scan_driver #(
    .DIGIT_CYCLES (DC),
    .GUARD_CYCLES (GC)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .value      (value),
    .dp         (dp),
    .blank_lz   (blank_lz),
    .brightness (brightness),
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .an_n       (an_n),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle=%0d got=%h exp=%h", tag, e, got, exp);
    end
  endtask

  task automatic model_reset();
    e     = 0;
    m_val = '0;
    m_dp  = '0;
    m_blz = 1'b0;
    m_br  = '0;
  endtask

  task automatic step(input int n);
    int          st, s, d, p;
    logic [15:0] up;
    logic        blk, on;
    logic [6:0]  x_seg;
    logic        x_dp, x_ft;
    logic [3:0]  x_an;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      e++;
      st    = e - 1;
      s     = st % DC;
      d     = (st / DC) % 4;
      p     = st % 16;
      up    = m_val >> (4 * d);
      blk   = m_blz && (d != 0) && (up == 16'h0);
      x_seg = blk ? 7'h7F : font[up[3:0]];
      x_dp  = blk ? 1'b1 : !m_dp[d];
      on    = !blk && (s >= GC) && (m_br == 4'hF || p < int'(m_br));
      x_an  = on ? (4'hF & ~(4'h1 << d)) : 4'hF;
      x_ft  = (e % FRAME) == 0;
      if (x_ft) begin
        m_val = value;
        m_dp  = dp;
        m_blz = blank_lz;
        m_br  = brightness;
      end
      @(negedge clk);
      check("seg_n", 16'(seg_n), 16'(x_seg));
      check("dp_n", 16'(dp_n), 16'(x_dp));
      check("an_n", 16'(an_n), 16'(x_an));
      check("frame_tick", 16'(frame_tick), 16'(x_ft));
    end
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_an"}, 16'(an_n), 16'hF);
    check({tag, "_seg"}, 16'(seg_n), 16'h7F);
    check({tag, "_dp"}, 16'(dp_n), 16'h1);
    check({tag, "_ft"}, 16'(frame_tick), 16'h0);
  endtask

  task automatic set_in(input logic [15:0] v, input logic [3:0] d,
                        input logic z, input logic [3:0] b);
    value      = v;
    dp         = d;
    blank_lz   = z;
    brightness = b;
  endtask

  initial begin
    model_reset();
    repeat (5) @(negedge clk);
    check_reset_outs("rst");
    set_in(16'h3136, 4'h0, 1'b0, 4'hF);
    reset_n = 1'b1;
    step(3 * FRAME);

    set_in(16'h000A, 4'h0, 1'b1, 4'hF);
    step(2 * FRAME);
    set_in(16'h0000, 4'h0, 1'b1, 4'hF);
    step(2 * FRAME);

    set_in(16'h1234, 4'h0, 1'b0, 4'hF);
    step(2 * FRAME + 2 * DC - (e % FRAME));
    set_in(16'hABCD, 4'h0, 1'b0, 4'hF);
    step(2 * FRAME);

    set_in(16'h5A5A, 4'h0, 1'b0, 4'h4);
    step(2 * FRAME);
    set_in(16'h5A5A, 4'h0, 1'b0, 4'h0);
    step(2 * FRAME);

    set_in(16'hFFFF, 4'b0101, 1'b0, 4'hF);
    step(2 * FRAME);

    step(21);
    #2 reset_n = 1'b0;
    #1 check_reset_outs("midrst");
    repeat (3) @(negedge clk);
    check_reset_outs("midrst_hold");
    model_reset();
    reset_n = 1'b1;
    step(FRAME + 5);

    for (int k = 0; k < 40; k++) begin
      set_in(16'($urandom), 4'($urandom), 1'($urandom),
             4'($urandom));
      if (k % 4 == 0) value = 16'($urandom_range(0, 255));
      step($urandom_range(1, 100));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
